branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolver for the five-stage LA32R pipeline. It consumes the signed/unsigned less-than flags from the EX-stage comparator and the branch operands, decides taken/not-taken for every LA32R branch and jump, and computes the target address. On a taken branch it holds a registered redirect request until the fetch stage accepts it, and marks wrong-path instructions in EX as killed while the request is outstanding.

## Interface
Parameters:
- `XLEN`, 32: datapath width.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  the EX stage holds a valid instruction.
- `ex_stall`  in  1  EX is frozen this cycle; the instruction is not resolved.
- `ex_br_type`  in  4  branch type: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL. Codes 10–15 are treated as none.
- `ex_pc`  in  XLEN  PC of the EX instruction.
- `ex_imm`  in  XLEN  sign-extended offset, already shifted left by 2.
- `ex_rj`  in  XLEN  rj operand value.
- `ex_rd`  in  XLEN  rd operand value (second compare operand).
- `cmp_ul`  in  1  unsigned rj < rd, from the comparator.
- `cmp_sl`  in  1  signed rj < rd, from the comparator.
- `redirect_ready`  in  1  fetch accepts the redirect this cycle.
- `redirect_valid`  out  XLEN-independent 1  redirect request pending.
- `redirect_pc`  out  XLEN  target fetch address.
- `redirect_ade`  out  1  target is misaligned (target[1:0] != 0).
- `flush`  out  1  flush IF/ID and ID/EX. Equal to `redirect_valid`.
- `ex_kill`  out  1  the current EX instruction is wrong-path; it must not write back.
- `link_data`  out  XLEN  ex_pc + 4. Combinational; used by BL/JIRL writeback.

## Operation
- Equality is computed internally: `eq = (ex_rj == ex_rd)`.
- Taken condition by branch type:
  - BEQ: eq
  - BNE: !eq
  - BLT: cmp_sl
  - BGE: !cmp_sl
  - BLTU: cmp_ul
  - BGEU: !cmp_ul
  - B, BL, JIRL: always taken
  - none: never taken
- Target address:
  - JIRL: ex_rj + ex_imm.
  - All other types: ex_pc + ex_imm.
  - Both are modulo-2^XLEN adds; carry is discarded.
- `resolve = ex_valid & !ex_stall & taken & (state == IDLE)`.
- State machine:
  - IDLE: on `resolve`, capture target and ade, then go to PEND. Otherwise stay.
  - PEND: `redirect_valid = 1`, `ex_kill = ex_valid`.
  - PEND: when `redirect_ready` is high, go to IDLE. Otherwise hold; captured target and ade stay stable.
- Branches arriving in EX while in PEND are wrong-path. They are ignored even in the cycle where `redirect_ready` is high; no back-to-back capture.
- A not-taken branch causes no state change and no output activity.
- A misaligned target is still redirected with `redirect_ade = 1`. The exception itself is raised downstream.

## Timing
- Reset values: state IDLE; `redirect_valid`, `flush`, `ex_kill`, `redirect_ade` all 0; `redirect_pc` 0.
- Latency: a branch resolved in cycle T asserts `redirect_valid` from cycle T+1.
- The request drops in the cycle after the first cycle with `redirect_ready` = 1. Minimum pulse is one cycle.
- `redirect_pc` and `redirect_ade` are registered and stable for the whole time `redirect_valid` is high.
- `ex_stall` = 1 blocks resolution. The branch resolves in the first cycle with `ex_stall` = 0.
- `rst` asserted during PEND clears the state immediately; the request is lost.
- `link_data` and the taken decision are combinational within the cycle.

## Configuration
- `BR_STATS_EN` defined:
  - Two extra outputs, `stat_branches` and `stat_taken`, each 32 bits and saturating at 0xFFFFFFFF.
  - `stat_branches` increments on every `ex_valid & !ex_stall & type != none & state == IDLE`.
  - `stat_taken` increments on every `resolve`.
  - Both reset to 0.
- `BR_STATS_EN` undefined: the counters and ports are absent; all other behaviour is identical.

## Test plan
- BEQ: rj = rd = 0x5, pc = 0x1C000000, imm = 0x10, ready = 1 → `redirect_valid` high for exactly 1 cycle at T+1, `redirect_pc` = 0x1C000010, `flush` = 1.
- BLT vs BLTU with rj = 0xFFFFFFFF, rd = 0x1 (sl = 1, ul = 0) → BLT taken; BLTU not taken, with `redirect_valid` staying 0.
- JIRL: rj = 0x1C001002, imm = 0x0 → `redirect_pc` = 0x1C001002, `redirect_ade` = 1; `link_data` = pc + 4.
- Taken B with ready = 0 for 3 cycles → request held 4 cycles with constant `redirect_pc`; a BNE in EX during PEND sees `ex_kill` = 1 and is not captured.
- Taken BGE during `ex_stall` = 1 for 2 cycles → `redirect_valid` rises one cycle after the stall releases.
- `rst` pulsed during PEND → all outputs 0 immediately. With `BR_STATS_EN`: 3 branches, 2 taken → `stat_branches` = 3, `stat_taken` = 2.

Source files
------------

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - EX-stage branch resolver bus: operands in, redirect handshake out.
// Optional BR_STATS_EN adds the branch/taken statistic counters.
interface branch_resolve_if #(parameter int XLEN = 32);
  logic            ex_valid;
  logic            ex_stall;
  logic [3:0]      ex_br_type;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rj;
  logic [XLEN-1:0] ex_rd;
  logic            cmp_ul;
  logic            cmp_sl;
  logic            redirect_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ade;
  logic            flush;
  logic            ex_kill;
  logic [XLEN-1:0] link_data;
`ifdef BR_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_taken;
`endif

  modport master (
`ifdef BR_STATS_EN
    input  stat_branches, stat_taken,
`endif
    output ex_valid, ex_stall, ex_br_type, ex_pc, ex_imm, ex_rj, ex_rd,
    output cmp_ul, cmp_sl, redirect_ready,
    input  redirect_valid, redirect_pc, redirect_ade, flush, ex_kill, link_data
  );

  modport slave (
`ifdef BR_STATS_EN
    output stat_branches, stat_taken,
`endif
    input  ex_valid, ex_stall, ex_br_type, ex_pc, ex_imm, ex_rj, ex_rd,
    input  cmp_ul, cmp_sl, redirect_ready,
    output redirect_valid, redirect_pc, redirect_ade, flush, ex_kill, link_data
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - LA32R execute-stage branch resolver with registered redirect request.
// Optional feature macro: BR_STATS_EN (saturating branch/taken counters).
module branch_resolve #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] T_BEQ  = 4'd1;
  localparam logic [3:0] T_BNE  = 4'd2;
  localparam logic [3:0] T_BLT  = 4'd3;
  localparam logic [3:0] T_BGE  = 4'd4;
  localparam logic [3:0] T_BLTU = 4'd5;
  localparam logic [3:0] T_BGEU = 4'd6;
  localparam logic [3:0] T_B    = 4'd7;
  localparam logic [3:0] T_BL   = 4'd8;
  localparam logic [3:0] T_JIRL = 4'd9;

  state_t          state;
  logic            eq;
  logic            taken;
  logic            resolve;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] target_q;
  logic            ade_q;
  logic            valid_q;

  assign eq = (bus.ex_rj == bus.ex_rd);

  always_comb begin
    taken = 1'b0;
    case (bus.ex_br_type)
      T_BEQ:             taken = eq;
      T_BNE:             taken = ~eq;
      T_BLT:             taken = bus.cmp_sl;
      T_BGE:             taken = ~bus.cmp_sl;
      T_BLTU:            taken = bus.cmp_ul;
      T_BGEU:            taken = ~bus.cmp_ul;
      T_B, T_BL, T_JIRL: taken = 1'b1;
      default:           taken = 1'b0;
    endcase
  end

  assign target  = (bus.ex_br_type == T_JIRL) ? (bus.ex_rj + bus.ex_imm)
                                              : (bus.ex_pc + bus.ex_imm);
  assign resolve = bus.ex_valid & ~bus.ex_stall & taken & (state == IDLE);

  // Wrong-path branches seen while PEND are ignored, even on the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      target_q <= '0;
      ade_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (resolve) begin
            state    <= PEND;
            valid_q  <= 1'b1;
            target_q <= target;
            ade_q    <= |target[1:0];
          end
        end
        PEND: begin
          if (bus.redirect_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = valid_q;
  assign bus.flush          = valid_q;
  assign bus.redirect_pc    = target_q;
  assign bus.redirect_ade   = ade_q;
  assign bus.ex_kill        = (state == PEND) & bus.ex_valid;
  assign bus.link_data      = bus.ex_pc + XLEN'(4);

`ifdef BR_STATS_EN
  logic        is_branch;
  logic        counted;
  logic [31:0] branches_q;
  logic [31:0] taken_q;

  assign is_branch = (bus.ex_br_type >= T_BEQ) && (bus.ex_br_type <= T_JIRL);
  assign counted   = bus.ex_valid & ~bus.ex_stall & is_branch & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q <= '0;
      taken_q    <= '0;
    end else begin
      if (counted && (branches_q != 32'hFFFF_FFFF)) branches_q <= branches_q + 32'd1;
      if (resolve && (taken_q != 32'hFFFF_FFFF))    taken_q    <= taken_q + 32'd1;
    end
  end

  assign bus.stat_branches = branches_q;
  assign bus.stat_taken    = taken_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed plus randomized checks of branch_resolve against a reference model.
// Honours BR_STATS_EN when the design is built with it.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   run_cmp = 1'b0;

  branch_resolve_if #(.XLEN(32)) bus ();

  branch_resolve #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_pend = 1'b0;
  logic [31:0] m_pc   = '0;
  bit          m_ade  = 1'b0;
  int unsigned m_nbr  = 0;
  int unsigned m_ntk  = 0;

  function automatic bit ref_taken(logic [3:0] t, logic [31:0] rj, logic [31:0] rd);
    case (t)
      4'd1: return rj == rd;
      4'd2: return rj != rd;
      4'd3: return $signed(rj) <  $signed(rd);
      4'd4: return $signed(rj) >= $signed(rd);
      4'd5: return rj <  rd;
      4'd6: return rj >= rd;
      4'd7, 4'd8, 4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      m_pc   = '0;
      m_ade  = 1'b0;
      m_nbr  = 0;
      m_ntk  = 0;
    end else if (m_pend) begin
      if (bus.redirect_ready) m_pend = 1'b0;
    end else if (bus.ex_valid && !bus.ex_stall) begin
      if (bus.ex_br_type >= 4'd1 && bus.ex_br_type <= 4'd9) m_nbr++;
      if (ref_taken(bus.ex_br_type, bus.ex_rj, bus.ex_rd)) begin
        m_pend = 1'b1;
        m_pc   = (bus.ex_br_type == 4'd9) ? bus.ex_rj + bus.ex_imm : bus.ex_pc + bus.ex_imm;
        m_ade  = (m_pc[1:0] != 2'b00);
        m_ntk++;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("m_valid", {31'b0, bus.redirect_valid}, {31'b0, m_pend});
      chk("m_flush", {31'b0, bus.flush}, {31'b0, m_pend});
      chk("m_kill", {31'b0, bus.ex_kill}, {31'b0, m_pend & bus.ex_valid});
      chk("m_link", bus.link_data, bus.ex_pc + 32'd4);
      if (m_pend) begin
        chk("m_pc", bus.redirect_pc, m_pc);
        chk("m_ade", {31'b0, bus.redirect_ade}, {31'b0, m_ade});
      end
`ifdef BR_STATS_EN
      chk("m_stat_br", bus.stat_branches, m_nbr);
      chk("m_stat_tk", bus.stat_taken, m_ntk);
`endif
    end
  end

  task automatic drv(bit v, bit s, logic [3:0] t, logic [31:0] pc, logic [31:0] imm,
                     logic [31:0] rj, logic [31:0] rd, bit rdy);
    bus.ex_valid       = v;
    bus.ex_stall       = s;
    bus.ex_br_type     = t;
    bus.ex_pc          = pc;
    bus.ex_imm         = imm;
    bus.ex_rj          = rj;
    bus.ex_rd          = rd;
    bus.cmp_sl         = $signed(rj) < $signed(rd);
    bus.cmp_ul         = rj < rd;
    bus.redirect_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit rdy);
    next_cycle();
    drv(0, 0, 4'd0, 32'h1C00_0000, 0, 0, 0, rdy);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drv(0, 0, 4'd0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_pc", bus.redirect_pc, 32'd0);
    chk("rst_ade", {31'b0, bus.redirect_ade}, 32'd0);
    chk("rst_flush", {31'b0, bus.flush}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_cmp = 1'b1;

    // BEQ taken, accepted immediately: one-cycle pulse
    next_cycle();
    drv(1, 0, 4'd1, 32'h1C00_0000, 32'h10, 32'h5, 32'h5, 1);
    @(negedge clk);
    chk("beq_T_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("beq_link", bus.link_data, 32'h1C00_0004);
    idle(1);
    @(negedge clk);
    chk("beq_T1_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("beq_pc", bus.redirect_pc, 32'h1C00_0010);
    chk("beq_flush", {31'b0, bus.flush}, 32'd1);
    idle(1);
    @(negedge clk);
    chk("beq_T2_valid", {31'b0, bus.redirect_valid}, 32'd0);

    // BLT taken, BLTU not taken on the same operands
    next_cycle();
    drv(1, 0, 4'd3, 32'h1C00_0020, 32'h8, 32'hFFFF_FFFF, 32'h1, 1);
    idle(1);
    @(negedge clk);
    chk("blt_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("blt_pc", bus.redirect_pc, 32'h1C00_0028);
    idle(1);
    next_cycle();
    drv(1, 0, 4'd5, 32'h1C00_0030, 32'h8, 32'hFFFF_FFFF, 32'h1, 1);
    idle(1);
    @(negedge clk);
    chk("bltu_valid", {31'b0, bus.redirect_valid}, 32'd0);

    // JIRL to a misaligned target
    next_cycle();
    drv(1, 0, 4'd9, 32'h1C00_0100, 32'h0, 32'h1C00_1002, 32'h0, 1);
    @(negedge clk);
    chk("jirl_link", bus.link_data, 32'h1C00_0104);
    idle(1);
    @(negedge clk);
    chk("jirl_pc", bus.redirect_pc, 32'h1C00_1002);
    chk("jirl_ade", {31'b0, bus.redirect_ade}, 32'd1);
    idle(1);

    // B held by fetch backpressure; BNE in EX during PEND is killed and dropped
    next_cycle();
    drv(1, 0, 4'd7, 32'h1C00_0200, 32'h40, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drv(1, 0, 4'd2, 32'h1C00_0204 + 32'(i * 4), 32'h80, 32'h1, 32'h2, i == 3);
      @(negedge clk);
      chk("b_hold_valid", {31'b0, bus.redirect_valid}, 32'd1);
      chk("b_hold_pc", bus.redirect_pc, 32'h1C00_0240);
      chk("b_kill", {31'b0, bus.ex_kill}, 32'd1);
    end
    idle(1);
    @(negedge clk);
    chk("b_drop_valid", {31'b0, bus.redirect_valid}, 32'd0);

    // BGE stalled for two cycles
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drv(1, i < 2, 4'd4, 32'h1C00_0300, 32'h20, 32'h3, 32'h3, 1);
      @(negedge clk);
      chk("bge_stall_valid", {31'b0, bus.redirect_valid}, 32'd0);
    end
    idle(1);
    @(negedge clk);
    chk("bge_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("bge_pc", bus.redirect_pc, 32'h1C00_0320);
    idle(1);

    // Reset during PEND drops the request at once
    next_cycle();
    drv(1, 0, 4'd7, 32'h1C00_0400, 32'h4, 0, 0, 0);
    next_cycle();
    drv(1, 0, 4'd0, 32'h1C00_0404, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstp_pre_valid", {31'b0, bus.redirect_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstp_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rstp_flush", {31'b0, bus.flush}, 32'd0);
    chk("rstp_kill", {31'b0, bus.ex_kill}, 32'd0);
    chk("rstp_pc", bus.redirect_pc, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Three branches, two taken
    next_cycle();
    drv(1, 0, 4'd1, 32'h1C00_0500, 32'h10, 32'h7, 32'h7, 1);
    idle(1);
    next_cycle();
    drv(1, 0, 4'd2, 32'h1C00_0508, 32'h10, 32'h7, 32'h7, 1);
    next_cycle();
    drv(1, 0, 4'd7, 32'h1C00_050C, 32'h10, 0, 0, 1);
    idle(1);
    idle(1);
    @(negedge clk);
`ifdef BR_STATS_EN
    chk("stat_branches", bus.stat_branches, 32'd3);
    chk("stat_taken", bus.stat_taken, 32'd2);
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] imm;
      next_cycle();
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
          {$urandom} & 32'hFFFF_FFFC, imm, pick_op(), pick_op(), $urandom_range(0, 2) != 0);
    end
    idle(1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
